// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: turns byte/half/word loads and stores into
// word-wide data_mem transactions, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int B = 32,
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [B-1:0] i_addr,
  input  logic [B-1:0] i_wr_data,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [1:0]   i_size,
  input  logic         i_unsigned,
  output logic         o_stall,
  output logic [B-1:0] o_load_data,
  output logic         o_load_valid,
  output logic         o_misaligned,
  output logic [W-1:0] o_mem_addr,
  output logic [B-1:0] o_mem_wdata,
  output logic         o_mem_read,
  output logic         o_mem_write,
  input  logic [B-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, EXTRACT, MERGE, WRITE} state_t;

  state_t       state_reg, state_next;
  logic         done_reg, done_next;
  logic         store_reg, store_next;
  logic         unsigned_reg, unsigned_next;
  logic [1:0]   size_reg, size_next;
  logic [W-1:0] addr_reg, addr_next;
  logic [B-1:0] wdata_reg, wdata_next;
  logic [B-1:0] load_data_reg, load_data_next;

  logic         request;
  logic         misaligned_req;
  logic         stall_c;
  logic         misaligned_c;
  logic         mem_read_c;
  logic         mem_write_c;
  logic         unused_addr;

  logic [7:0]   rd_byte [B/8];
  logic [B-1:0] merged_word;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [B-1:0] extracted_word;

  // Only the low W address bits reach memory.
  assign unused_addr = ^i_addr[B-1:W];

  assign request        = i_mem_read | i_mem_write;
  assign misaligned_req = ((i_size == 2'b01) & i_addr[0]) |
                          (i_size[1] & (|i_addr[1:0]));

  // Lane k takes store data when it is the addressed byte or part of the
  // addressed half; every other lane keeps the word just read.
  genvar gi;
  generate
    for (gi = 0; gi < B/8; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_wdata;
      assign rd_byte[gi] = i_mem_rdata[8*gi +: 8];
      assign lane_hit    = (size_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi))
                                               : (addr_reg[1] == 1'(gi / 2));
      assign lane_wdata  = (size_reg == 2'b00) ? wdata_reg[7:0]
                                               : wdata_reg[8*(gi % 2) +: 8];
      assign merged_word[8*gi +: 8] = lane_hit ? lane_wdata : rd_byte[gi];
    end
  endgenerate

  assign byte_sel = rd_byte[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    extracted_word = i_mem_rdata;
    case (size_reg)
      2'b00:   extracted_word = {{(B-8){~unsigned_reg & byte_sel[7]}}, byte_sel};
      2'b01:   extracted_word = {{(B-16){~unsigned_reg & half_sel[15]}}, half_sel};
      default: extracted_word = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    done_next      = 1'b0;
    store_next     = store_reg;
    unsigned_next  = unsigned_reg;
    size_next      = size_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    load_data_next = load_data_reg;
    stall_c        = 1'b1;
    misaligned_c   = 1'b0;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;

    case (state_reg)
      IDLE: begin
        stall_c = 1'b0;
        // The done cycle belongs to the request just served, so it is ignored.
        if (!done_reg && request) begin
          if (misaligned_req) begin
            misaligned_c = 1'b1;
          end else begin
            stall_c       = 1'b1;
            addr_next     = i_addr[W-1:0];
            wdata_next    = i_wr_data;
            size_next     = i_size;
            unsigned_next = i_unsigned;
            store_next    = i_mem_write;
            state_next    = (i_mem_write && i_size[1]) ? WRITE : READ;
          end
        end
      end
      READ: begin
        mem_read_c = 1'b1;
        state_next = store_reg ? MERGE : EXTRACT;
      end
      EXTRACT: begin
        load_data_next = extracted_word;
        done_next      = 1'b1;
        state_next     = IDLE;
      end
      MERGE: begin
        wdata_next = merged_word;
        state_next = WRITE;
      end
      WRITE: begin
        mem_write_c = 1'b1;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      done_reg      <= 1'b0;
      store_reg     <= 1'b0;
      unsigned_reg  <= 1'b0;
      size_reg      <= 2'b00;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      load_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      done_reg      <= done_next;
      store_reg     <= store_next;
      unsigned_reg  <= unsigned_next;
      size_reg      <= size_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      load_data_reg <= load_data_next;
    end
  end

  // Request-dependent outputs are masked so every output reads 0 in reset.
  assign o_stall      = stall_c & ~i_reset;
  assign o_misaligned = misaligned_c & ~i_reset;
  assign o_mem_read   = mem_read_c;
  assign o_mem_write  = mem_write_c;
  assign o_mem_addr   = (state_reg != IDLE) ? {addr_reg[W-1:2], 2'b00} : '0;
  assign o_mem_wdata  = (state_reg == WRITE) ? wdata_reg : '0;
  assign o_load_data  = load_data_reg;
  assign o_load_valid = done_reg & ~store_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table of load/store requests against a
// synchronous word memory, with a scoreboard for writes and load results.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic        o_load_valid;
  logic        o_misaligned;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] i_mem_rdata;

  mem_access_unit #(.B(32), .W(10)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_addr      (i_addr),
    .i_wr_data   (i_wr_data),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .o_stall     (o_stall),
    .o_load_data (o_load_data),
    .o_load_valid(o_load_valid),
    .o_misaligned(o_misaligned),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_read  (o_mem_read),
    .o_mem_write (o_mem_write),
    .i_mem_rdata (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (o_mem_write) mem[o_mem_addr[9:2]] <= o_mem_wdata;
    if (o_mem_read)  i_mem_rdata <= mem[o_mem_addr[9:2]];
  end

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          exp_stall;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t wr_q[$];
  exp_t ld_q[$];

  int   checks = 0;
  int   failures = 0;
  int   write_count = 0;
  int   valid_count = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic wr, input logic rd,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, input int exp_stall,
                              input logic exp_mis);
    vec_t v;
    v.name = name; v.wr = wr; v.rd = rd; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.exp = exp; v.exp_stall = exp_stall;
    v.exp_mis = exp_mis;
    return v;
  endfunction

  // Scoreboard side: every write pulse and load result is matched in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_read && o_mem_write) begin
        checks++; failures++;
        $display("FAIL rd_wr_overlap: read and write both high");
      end
      if (o_mem_write) begin
        write_count++;
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected",
                   o_mem_addr, o_mem_wdata);
        end else begin
          exp_t e;
          e = wr_q.pop_front();
          chk("write_addr", 32'(o_mem_addr), 32'(e.addr));
          chk("write_data", o_mem_wdata, e.data);
        end
      end
      if (o_load_valid) begin
        valid_count++;
        chk("valid_single_cycle", 32'(prev_valid), 32'd0);
        if (ld_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_load_valid: data 0x%08h, none expected", o_load_data);
        end else begin
          exp_t e;
          e = ld_q.pop_front();
          chk("load_data", o_load_data, e.data);
        end
      end
      prev_valid = o_load_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Presents one request, holds it through the stall and advances on the
  // first o_stall=0 cycle, as the pipeline would.
  task automatic run_vec(input vec_t v);
    int   cyc;
    logic seen;
    exp_t e;
    i_mem_write = v.wr;
    i_mem_read  = v.rd;
    i_size      = v.size;
    i_unsigned  = v.uns;
    i_addr      = v.addr;
    i_wr_data   = v.wdata;
    e.addr = {v.addr[9:2], 2'b00};
    e.data = v.exp;
    if (!v.exp_mis) begin
      if (v.wr) wr_q.push_back(e);
      else      ld_q.push_back(e);
    end
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!o_stall) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout: stall still high after %0d cycles", v.name, cyc);
    end else begin
      chk({v.name, "_stall_cycles"}, 32'(cyc), 32'(v.exp_stall));
      chk({v.name, "_misaligned"}, 32'(o_misaligned), 32'(v.exp_mis));
      chk({v.name, "_load_valid"}, 32'(o_load_valid), 32'(v.rd & ~v.wr & ~v.exp_mis));
      if (v.exp_mis)
        chk({v.name, "_no_mem_access"}, {30'd0, o_mem_read, o_mem_write}, 32'd0);
    end
    @(posedge clk);
    #1;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_stall"}, 32'(o_stall), 32'd0);
    chk({tag, "_load_data"}, o_load_data, 32'd0);
    chk({tag, "_load_valid"}, 32'(o_load_valid), 32'd0);
    chk({tag, "_misaligned"}, 32'(o_misaligned), 32'd0);
    chk({tag, "_mem_rw"}, {30'd0, o_mem_read, o_mem_write}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
  endtask

  logic [31:0] snap_004;
  logic [31:0] snap_010;
  int          wc0;
  int          vc0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst = 1'b1;
    // A misaligned request during reset must not show on any output.
    i_mem_read = 1'b1; i_mem_write = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
    i_addr = 32'h006; i_wr_data = 32'd0;

    //              name        wr rd size   uns addr     wdata          exp            stall mis
    vecs.push_back(mk("sw_008",  1, 0, 2'b10, 0, 32'h008, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0));
    vecs.push_back(mk("lw_008",  0, 1, 2'b10, 0, 32'h008, 32'h0,        32'hDEADBEEF, 3, 0));
    vecs.push_back(mk("sw_00c",  1, 0, 2'b10, 0, 32'h00C, 32'h11223344, 32'h11223344, 2, 0));
    vecs.push_back(mk("sb_00d",  1, 0, 2'b00, 0, 32'h00D, 32'hCAFEBA80, 32'h11228044, 4, 0));
    vecs.push_back(mk("lb_00d",  0, 1, 2'b00, 0, 32'h00D, 32'h0,        32'hFFFFFF80, 3, 0));
    vecs.push_back(mk("lbu_00d", 0, 1, 2'b00, 1, 32'h00D, 32'h0,        32'h00000080, 3, 0));
    vecs.push_back(mk("lb_00c",  0, 1, 2'b00, 0, 32'h00C, 32'h0,        32'h00000044, 3, 0));
    vecs.push_back(mk("lbu_00f", 0, 1, 2'b00, 1, 32'h00F, 32'h0,        32'h00000011, 3, 0));
    vecs.push_back(mk("sw_010",  1, 0, 2'b10, 0, 32'h010, 32'h00000000, 32'h00000000, 2, 0));
    vecs.push_back(mk("sh_012",  1, 0, 2'b01, 0, 32'h012, 32'h1234BEEF, 32'hBEEF0000, 4, 0));
    vecs.push_back(mk("lh_012",  0, 1, 2'b01, 0, 32'h012, 32'h0,        32'hFFFFBEEF, 3, 0));
    vecs.push_back(mk("lhu_012", 0, 1, 2'b01, 1, 32'h012, 32'h0,        32'h0000BEEF, 3, 0));
    vecs.push_back(mk("sb_010",  1, 0, 2'b00, 0, 32'h010, 32'hFFFFFF7F, 32'hBEEF007F, 4, 0));
    vecs.push_back(mk("lb_010",  0, 1, 2'b00, 0, 32'h010, 32'h0,        32'h0000007F, 3, 0));
    vecs.push_back(mk("lh_010",  0, 1, 2'b01, 0, 32'h010, 32'h0,        32'h0000007F, 3, 0));
    vecs.push_back(mk("lw_00c",  0, 1, 2'b11, 0, 32'h00C, 32'h0,        32'h11228044, 3, 0));

    @(negedge clk);
    check_outputs_zero("reset");
    i_mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    snap_004 = mem[1];
    snap_010 = mem[4];
    run_vec(mk("mis_lw_006", 0, 1, 2'b10, 0, 32'h006, 32'h0,        32'h0, 0, 1));
    run_vec(mk("mis_sh_011", 1, 0, 2'b01, 0, 32'h011, 32'h00005555, 32'h0, 0, 1));
    chk("mis_mem_004", mem[1], snap_004);
    chk("mis_mem_010", mem[4], 32'hBEEF007F);

    // Reset lands while SB 0x55 at 0x00C is in MERGE.
    i_mem_write = 1'b1; i_mem_read = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
    i_addr = 32'h00D; i_wr_data = 32'h00000055;
    i_addr = 32'h00C;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("merge_stall", 32'(o_stall), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort");
    i_mem_write = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_mem_00c", mem[3], 32'h11228044);
    run_vec(mk("lw_00c_post", 0, 1, 2'b10, 0, 32'h00C, 32'h0, 32'h11228044, 3, 0));

    // Store then load back-to-back with no idle gap in between.
    wc0 = write_count;
    vc0 = valid_count;
    run_vec(mk("sw_020", 1, 0, 2'b10, 0, 32'h020, 32'hA5A5A5A5, 32'hA5A5A5A5, 2, 0));
    run_vec(mk("lw_020", 0, 1, 2'b10, 0, 32'h020, 32'h0,        32'hA5A5A5A5, 3, 0));
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_write_count", 32'(write_count - wc0), 32'd1);
    chk("b2b_valid_count", 32'(valid_count - vc0), 32'd1);
    chk("b2b_mem_020", mem[8], 32'hA5A5A5A5);

    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
